// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter: access sizes, FSM states,
// and the sub-word lane merge used by read-modify-write stores.
package data_mem_arbiter_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned LANE_W = 2;

   typedef enum logic [1:0] {
      SIZE_WORD     = 2'b00,
      SIZE_HALF     = 2'b01,
      SIZE_BYTE     = 2'b10,
      SIZE_WORD_ALT = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ACCESS    = 2'd1,
      ST_RMW_READ  = 2'd2,
      ST_RMW_WRITE = 2'd3
   } state_e;

   function automatic logic is_subword(input size_e size);
      return (size == SIZE_HALF) || (size == SIZE_BYTE);
   endfunction

   function automatic logic is_misaligned(input size_e size, input logic [LANE_W-1:0] lane);
      return (size == SIZE_HALF) && lane[0];
   endfunction

   // Little-endian lane insert: byte lane = lane, half lane = lane[1].
   function automatic logic [WORD_W-1:0] merge_lanes(
      input logic [WORD_W-1:0] old_word,
      input logic [WORD_W-1:0] wdata,
      input size_e             size,
      input logic [LANE_W-1:0] lane
   );
      logic [WORD_W-1:0] merged;
      merged = old_word;
      case (size)
         SIZE_HALF: merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         SIZE_BYTE: merged[{lane, 3'b000} +: 8]      = wdata[7:0];
         default:   merged                           = wdata;
      endcase
      return merged;
   endfunction

endpackage

// File: rtl/data_mem_arbiter_store_merge.sv
// Combinational merge of store data into the old memory word for sub-word stores.
module data_mem_arbiter_store_merge
   import data_mem_arbiter_pkg::*;
(
   input  logic [WORD_W-1:0] old_word,
   input  logic [WORD_W-1:0] wdata,
   input  size_e             size,
   input  logic [LANE_W-1:0] lane,
   output logic [WORD_W-1:0] merged_c
);

   assign merged_c = merge_lanes(old_word, wdata, size, lane);

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: round-robin grant between
// the pipeline port (P0, byte/half/word) and the loader port (P1, word only).
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Rst,

   input  logic              P0_Req,
   input  logic              P0_Write,
   input  logic [1:0]        P0_Size,
   input  logic [ADDR_W-1:0] P0_Addr,
   input  logic [DATA_W-1:0] P0_WData,
   output logic              P0_Ack,
   output logic [DATA_W-1:0] P0_RData,
   output logic              P0_Err,
   output logic              Stall,

   input  logic              P1_Req,
   input  logic              P1_Write,
   input  logic [ADDR_W-1:0] P1_Addr,
   input  logic [DATA_W-1:0] P1_WData,
   output logic              P1_Ack,
   output logic [DATA_W-1:0] P1_RData,

   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] Mem_WData,
   output logic              Mem_Read,
   output logic              Mem_Write,
   input  logic [DATA_W-1:0] Mem_RData
);

   state_e              state_q;
   logic                prio_p1_q;
   size_e               size_q;
   logic [LANE_W-1:0]   lane_q;
   logic [DATA_W-1:0]   wdata_q;

   logic                p0_ack_q;
   logic                p0_err_q;
   logic                p1_ack_q;
   logic                mem_read_q;
   logic                mem_write_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;

   logic                grant_p0;
   logic                grant_p1;
   logic                g_write;
   size_e               g_size;
   logic [ADDR_W-1:0]   g_addr;
   logic [DATA_W-1:0]   g_wdata;
   logic                g_misaligned;
   logic                g_rmw;
   logic [DATA_W-1:0]   merged;

   // Grant selection and the fields of the winning port.
   always_comb begin
      grant_p0     = P0_Req & (~P1_Req | ~prio_p1_q);
      grant_p1     = P1_Req & ~grant_p0;
      g_write      = P0_Write;
      g_size       = size_e'(P0_Size);
      g_addr       = P0_Addr;
      g_wdata      = P0_WData;
      if (grant_p1) begin
         g_write = P1_Write;
         g_size  = SIZE_WORD;
         g_addr  = P1_Addr;
         g_wdata = P1_WData;
      end
      g_misaligned = is_misaligned(g_size, g_addr[1:0]);
      g_rmw        = g_write & is_subword(g_size) & ~g_misaligned;
   end

   data_mem_arbiter_store_merge store_merge (
      .old_word (Mem_RData),
      .wdata    (wdata_q),
      .size     (size_q),
      .lane     (lane_q),
      .merged_c (merged)
   );

   // Arbiter FSM with registered memory-side and ack outputs.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q     <= ST_IDLE;
         prio_p1_q   <= 1'b0;
         size_q      <= SIZE_WORD;
         lane_q      <= '0;
         wdata_q     <= '0;
         p0_ack_q    <= 1'b0;
         p0_err_q    <= 1'b0;
         p1_ack_q    <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         p0_ack_q    <= 1'b0;
         p0_err_q    <= 1'b0;
         p1_ack_q    <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant_p0 | grant_p1) begin
                  prio_p1_q  <= grant_p0;
                  size_q     <= g_size;
                  lane_q     <= g_addr[1:0];
                  wdata_q    <= g_wdata;
                  mem_addr_q <= {g_addr[ADDR_W-1:2], 2'b00};
                  if (g_misaligned) begin
                     state_q  <= ST_ACCESS;
                     p0_ack_q <= 1'b1;
                     p0_err_q <= 1'b1;
                  end else if (g_rmw) begin
                     state_q    <= ST_RMW_READ;
                     mem_read_q <= 1'b1;
                  end else begin
                     state_q     <= ST_ACCESS;
                     mem_read_q  <= ~g_write;
                     mem_write_q <= g_write;
                     p0_ack_q    <= grant_p0;
                     p1_ack_q    <= grant_p1;
                     if (g_write) begin
                        mem_wdata_q <= g_wdata;
                     end
                  end
               end
            end
            ST_ACCESS: begin
               state_q <= ST_IDLE;
            end
            // The write-data register doubles as the merge register for the RMW word.
            ST_RMW_READ: begin
               state_q     <= ST_RMW_WRITE;
               mem_wdata_q <= merged;
               mem_write_q <= 1'b1;
               p0_ack_q    <= 1'b1;
            end
            ST_RMW_WRITE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Reset masks outputs immediately so an in-flight RMW write never reaches memory.
   assign P0_Ack    = p0_ack_q & Rst;
   assign P0_Err    = p0_err_q & Rst;
   assign P1_Ack    = p1_ack_q & Rst;
   assign Mem_Read  = mem_read_q & Rst;
   assign Mem_Write = mem_write_q & Rst;
   assign Mem_Addr  = Rst ? mem_addr_q : '0;
   assign Mem_WData = Rst ? mem_wdata_q : '0;

   // Memory reads are combinational, so load data is forwarded during the Ack cycle.
   assign P0_RData  = P0_Ack ? Mem_RData : '0;
   assign P1_RData  = P1_Ack ? Mem_RData : '0;
   assign Stall     = P0_Req & ~P0_Ack;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a word memory model and an ack scoreboard.
module tb_data_mem_arbiter;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        P0_Req, P0_Write;
   logic [1:0]  P0_Size;
   logic [31:0] P0_Addr, P0_WData, P0_RData;
   logic        P0_Ack, P0_Err, Stall;
   logic        P1_Req, P1_Write;
   logic [31:0] P1_Addr, P1_WData, P1_RData;
   logic        P1_Ack;
   logic [31:0] Mem_Addr, Mem_WData, Mem_RData;
   logic        Mem_Read, Mem_Write;

   typedef struct packed {
      logic        port;
      logic        chk_rd;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          passes = 0;
   int          cycle = 0;
   int          ack_count = 0;
   logic        prev_ack = 1'b0;

   logic [31:0] mem [0:63];
   logic        pl_we = 1'b0;
   logic [5:0]  pl_idx = '0;
   logic [31:0] pl_data = '0;
   wire         unused_addr_bits = ^{Mem_Addr[31:8], Mem_Addr[1:0]};

   always #5 Clk = ~Clk;

   assign Mem_RData = mem[Mem_Addr[7:2]];

   always @(posedge Clk) begin
      if (pl_we) mem[pl_idx] <= pl_data;
      else if (Mem_Write) mem[Mem_Addr[7:2]] <= Mem_WData;
   end

   data_mem_arbiter dut (
      .Clk(Clk), .Rst(Rst),
      .P0_Req(P0_Req), .P0_Write(P0_Write), .P0_Size(P0_Size), .P0_Addr(P0_Addr),
      .P0_WData(P0_WData), .P0_Ack(P0_Ack), .P0_RData(P0_RData), .P0_Err(P0_Err),
      .Stall(Stall),
      .P1_Req(P1_Req), .P1_Write(P1_Write), .P1_Addr(P1_Addr), .P1_WData(P1_WData),
      .P1_Ack(P1_Ack), .P1_RData(P1_RData),
      .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Mem_Read(Mem_Read),
      .Mem_Write(Mem_Write), .Mem_RData(Mem_RData)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Advance to the next negedge and score any ack against the queue.
   task automatic tick();
      exp_t e;
      @(negedge Clk);
      cycle++;
      check("rw_exclusive", 32'(Mem_Read & Mem_Write), 32'd0);
      if (prev_ack) check("ack_gap", 32'(P0_Ack | P1_Ack), 32'd0);
      if (P0_Ack || P1_Ack) begin
         ack_count++;
         check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("ack_port", 32'(P1_Ack), 32'(e.port));
            check("ack_single", 32'(P0_Ack & P1_Ack), 32'd0);
            check("ack_err", 32'(P0_Err), 32'(e.err));
            if (e.chk_rd) check("ack_rdata", e.port ? P1_RData : P0_RData, e.rdata);
         end
      end
      prev_ack = P0_Ack | P1_Ack;
   endtask

   task automatic preload(input logic [5:0] idx, input logic [31:0] data);
      pl_we = 1'b1; pl_idx = idx; pl_data = data;
      tick();
      pl_we = 1'b0;
   endtask

   task automatic p0_access(input string tag, input logic wr, input logic [1:0] sz,
                            input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                            input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err);
      int   start;
      logic seen;
      exp_q.push_back('{port: 1'b0, chk_rd: chk_rd, rdata: exp_rd, err: exp_err});
      P0_Req = 1'b1; P0_Write = wr; P0_Size = sz; P0_Addr = addr; P0_WData = wd;
      #1 check({tag, "_stall_req"}, 32'(Stall), 32'd1);
      start = cycle;
      seen  = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
         tick();
         if (P0_Ack) seen = 1'b1;
         else check({tag, "_stall_wait"}, 32'(Stall), 32'd1);
      end
      check({tag, "_ack_seen"}, 32'(seen), 32'd1);
      check({tag, "_latency"}, 32'(cycle - start), 32'(exp_lat));
      check({tag, "_stall_ack"}, 32'(Stall), 32'd0);
      P0_Req = 1'b0;
      tick();
   endtask

   task automatic p1_access(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic chk_rd, input logic [31:0] exp_rd);
      int   start;
      logic seen;
      exp_q.push_back('{port: 1'b1, chk_rd: chk_rd, rdata: exp_rd, err: 1'b0});
      P1_Req = 1'b1; P1_Write = wr; P1_Addr = addr; P1_WData = wd;
      start = cycle;
      seen  = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
         tick();
         if (P1_Ack) seen = 1'b1;
      end
      check({tag, "_ack_seen"}, 32'(seen), 32'd1);
      check({tag, "_latency"}, 32'(cycle - start), 32'd1);
      P1_Req = 1'b0;
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      Rst = 1'b0;
      P0_Req = 1'b0; P0_Write = 1'b0; P0_Size = 2'b00; P0_Addr = '0; P0_WData = '0;
      P1_Req = 1'b0; P1_Write = 1'b0; P1_Addr = '0; P1_WData = '0;
      repeat (3) tick();
      check("rst_p0_ack", 32'(P0_Ack), 32'd0);
      check("rst_p1_ack", 32'(P1_Ack), 32'd0);
      check("rst_p0_err", 32'(P0_Err), 32'd0);
      check("rst_mem_read", 32'(Mem_Read), 32'd0);
      check("rst_mem_write", 32'(Mem_Write), 32'd0);
      check("rst_mem_addr", Mem_Addr, 32'd0);
      check("rst_mem_wdata", Mem_WData, 32'd0);
      check("rst_p0_rdata", P0_RData, 32'd0);
      check("rst_stall", 32'(Stall), 32'd0);
      Rst = 1'b1;
      tick();

      // Word load, then byte stores/loads on the same word.
      preload(6'd4, 32'hDEADBEEF);
      p0_access("ld_w10", 1'b0, 2'b00, 32'h10, 32'h0, 1, 1'b1, 32'hDEADBEEF, 1'b0);
      preload(6'd4, 32'h11223344);
      p0_access("st_b13", 1'b1, 2'b10, 32'h13, 32'h000000AB, 2, 1'b0, 32'h0, 1'b0);
      check("mem_after_st_b13", mem[4], 32'hAB223344);
      p0_access("ld_b13", 1'b0, 2'b10, 32'h13, 32'h0, 1, 1'b1, 32'hAB223344, 1'b0);
      p0_access("st_b10", 1'b1, 2'b10, 32'h10, 32'hFFFFFFCD, 2, 1'b0, 32'h0, 1'b0);
      check("mem_after_st_b10", mem[4], 32'hAB2233CD);

      // Half stores on both lanes and misaligned halves.
      preload(6'd8, 32'h11223344);
      p0_access("st_h22", 1'b1, 2'b01, 32'h22, 32'h00005566, 2, 1'b0, 32'h0, 1'b0);
      check("mem_after_st_h22", mem[8], 32'h55663344);
      p0_access("st_h21", 1'b1, 2'b01, 32'h21, 32'h00009999, 1, 1'b0, 32'h0, 1'b1);
      check("mem_after_st_h21", mem[8], 32'h55663344);
      p0_access("st_h20", 1'b1, 2'b01, 32'h20, 32'hABCD7788, 2, 1'b0, 32'h0, 1'b0);
      check("mem_after_st_h20", mem[8], 32'h55667788);
      p0_access("ld_h23", 1'b0, 2'b01, 32'h23, 32'h0, 1, 1'b0, 32'h0, 1'b1);

      // Size 11 behaves as a word store to the aligned address.
      p0_access("st_s3_31", 1'b1, 2'b11, 32'h31, 32'h01020304, 1, 1'b0, 32'h0, 1'b0);
      check("mem_after_st_s3", mem[12], 32'h01020304);

      // Reset during RMW_WRITE drops the store.
      preload(6'd20, 32'h11223344);
      P0_Req = 1'b1; P0_Write = 1'b1; P0_Size = 2'b10; P0_Addr = 32'h50; P0_WData = 32'hEE;
      tick();
      check("rmw_rd_mem_read", 32'(Mem_Read), 32'd1);
      check("rmw_rd_mem_addr", Mem_Addr, 32'h50);
      @(posedge Clk);
      #1 Rst = 1'b0;
      #1 check("rmw_rst_mem_write", 32'(Mem_Write), 32'd0);
      check("rmw_rst_p0_ack", 32'(P0_Ack), 32'd0);
      P0_Req = 1'b0;
      tick();
      tick();
      check("rmw_rst_mem_unchanged", mem[20], 32'h11223344);
      check("rmw_rst_mem_addr", Mem_Addr, 32'd0);
      Rst = 1'b1;
      tick();

      // Both ports requesting continuously: P0 first after reset, then alternate.
      base = ack_count;
      for (int g = 0; g < 6; g++) begin
         if (g % 2 == 0) exp_q.push_back('{port: 1'b0, chk_rd: 1'b1, rdata: 32'hAB2233CD, err: 1'b0});
         else            exp_q.push_back('{port: 1'b1, chk_rd: 1'b1, rdata: 32'h55667788, err: 1'b0});
      end
      P0_Req = 1'b1; P0_Write = 1'b0; P0_Size = 2'b00; P0_Addr = 32'h10;
      P1_Req = 1'b1; P1_Write = 1'b0; P1_Addr = 32'h20;
      for (int i = 0; i < 30 && ack_count < base + 6; i++) tick();
      check("rr_grants", 32'(ack_count - base), 32'd6);
      P0_Req = 1'b0; P1_Req = 1'b0;
      tick();

      // Loader store followed by pipeline load of the same word.
      p1_access("p1_st_40", 1'b1, 32'h40, 32'hCAFEF00D, 1'b0, 32'h0);
      check("mem_after_p1_st", mem[16], 32'hCAFEF00D);
      p0_access("ld_w40", 1'b0, 2'b00, 32'h40, 32'h0, 1, 1'b1, 32'hCAFEF00D, 1'b0);

      tick();
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
